// File: rtl/cordic_seq_ctrl.sv
// Rotation-mode CORDIC sequencer: one shared 16-bit add/sub, three cycles per micro-rotation.
// Latency: done pulses 3*ITER+1 cycles after the cycle in which start is asserted.
// No backpressure: start is ignored while busy; x/y/z outputs are qualified by done.
module cordic_seq_ctrl #(
  parameter int ITER = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UPD_X = 3'd1,
    UPD_Y = 3'd2,
    UPD_Z = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ITER - 1);

  state_t             state;
  logic [3:0]         idx;
  logic [15:0]        x_r;
  logic [15:0]        y_r;
  logic [15:0]        z_r;
  logic [15:0]        tmp_r;

  logic               z_neg;
  logic signed [15:0] x_sh;
  logic signed [15:0] y_sh;
  logic [15:0]        atan_val;
  logic [15:0]        add_a;
  logic [15:0]        add_b;
  logic               add_sub;
  logic [15:0]        add_sum;

  // Direction comes from the sign of z, which only moves at the end of UPD_Z.
  assign z_neg = z_r[15];
  assign x_sh  = $signed(x_r) >>> idx;
  assign y_sh  = $signed(y_r) >>> idx;

  // Arctangent table, atan(2^-i) scaled so that 2^15 represents pi.
  always_comb begin
    atan_val = 16'd0;
    case (idx)
      4'd0:    atan_val = 16'd8192;
      4'd1:    atan_val = 16'd4836;
      4'd2:    atan_val = 16'd2555;
      4'd3:    atan_val = 16'd1297;
      4'd4:    atan_val = 16'd651;
      4'd5:    atan_val = 16'd326;
      4'd6:    atan_val = 16'd163;
      4'd7:    atan_val = 16'd81;
      4'd8:    atan_val = 16'd41;
      4'd9:    atan_val = 16'd20;
      4'd10:   atan_val = 16'd10;
      4'd11:   atan_val = 16'd5;
      4'd12:   atan_val = 16'd3;
      4'd13:   atan_val = 16'd1;
      4'd14:   atan_val = 16'd1;
      default: atan_val = 16'd0;
    endcase
  end

  // Operand mux for the single shared adder; subtract is a + ~b + 1.
  always_comb begin
    add_a   = x_r;
    add_b   = y_sh;
    add_sub = ~z_neg;
    case (state)
      UPD_X: begin
        add_a   = x_r;
        add_b   = y_sh;
        add_sub = ~z_neg;
      end
      UPD_Y: begin
        add_a   = y_r;
        add_b   = x_sh;
        add_sub = z_neg;
      end
      UPD_Z: begin
        add_a   = z_r;
        add_b   = atan_val;
        add_sub = ~z_neg;
      end
      default: begin
        add_a   = x_r;
        add_b   = y_sh;
        add_sub = ~z_neg;
      end
    endcase
    add_sum = add_a + (add_b ^ {16{add_sub}}) + {15'd0, add_sub};
  end

  // Sequencer FSM with datapath registers and registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 4'd0;
      x_r   <= 16'd0;
      y_r   <= 16'd0;
      z_r   <= 16'd0;
      tmp_r <= 16'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_r   <= x_in;
            y_r   <= y_in;
            z_r   <= z_in;
            idx   <= 4'd0;
            busy  <= 1'b1;
            state <= UPD_X;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        UPD_X: begin
          // x update is parked in tmp so UPD_Y still sees the old x.
          tmp_r <= add_sum;
          state <= UPD_Y;
        end
        UPD_Y: begin
          y_r   <= add_sum;
          state <= UPD_Z;
        end
        UPD_Z: begin
          x_r <= tmp_r;
          z_r <= add_sum;
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= UPD_X;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign x_out = x_r;
  assign y_out = y_r;
  assign z_out = z_r;

endmodule
